// File: rtl/ready_run_controller.sv
// Launches one timed run per fresh rise of the Start detector's READY level.
// Each run ends in done or abort and is followed by a fixed cool-down lockout.
module ready_run_controller #(
  parameter int RUN_CYCLES  = 16,
  parameter int COOL_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             detector_out,
  input  logic             enable,
  input  logic             count_clr,
  output logic             run_active,
  output logic             done_pulse,
  output logic             abort_pulse,
  output logic [CNT_W-1:0] run_count,
  output logic [1:0]       state_dbg
);

  localparam int MAX_CYC = (RUN_CYCLES > COOL_CYCLES) ? RUN_CYCLES : COOL_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] RUN_LOAD  = TMR_W'(RUN_CYCLES - 1);
  localparam logic [TMR_W-1:0] COOL_LOAD = TMR_W'(COOL_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_COOL = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             det_q;
  logic             rise;
  logic             done_d, abort_d, count_inc;

  // det_q resets high so a level already present at reset release is not a rise.
  assign rise = detector_out & ~det_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      det_q       <= 1'b1;
      done_pulse  <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      det_q       <= detector_out;
      done_pulse  <= done_d;
      abort_pulse <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    count_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && rise) begin
          state_d = ST_RUN;
          timer_d = RUN_LOAD;
        end
      end
      ST_RUN: begin
        // Abort is tested first so it wins over a completion on the same edge.
        if (!detector_out || !enable) begin
          state_d = ST_COOL;
          abort_d = 1'b1;
          timer_d = COOL_LOAD;
        end else if (timer_q == '0) begin
          state_d   = ST_COOL;
          done_d    = 1'b1;
          count_inc = 1'b1;
          timer_d   = COOL_LOAD;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      ST_COOL: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_count <= '0;
    end else if (count_clr) begin
      run_count <= '0;
    end else if (count_inc && (run_count != '1)) begin
      run_count <= run_count + CNT_ONE;
    end
  end

  assign run_active = (state_q == ST_RUN);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_ready_run_controller.sv
// Bench for ready_run_controller: a table of scripted vectors, hand-written corner
// sequences and random stimulus, all compared against an edge-indexed reference model.
module tb_ready_run_controller;

  localparam int RUN     = 16;
  localparam int COOL    = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             detector_out;
  logic             enable;
  logic             count_clr;
  logic             run_active;
  logic             done_pulse;
  logic             abort_pulse;
  logic [CNT_W-1:0] run_count;
  logic [1:0]       state_dbg;

  ready_run_controller #(
    .RUN_CYCLES (RUN),
    .COOL_CYCLES(COOL),
    .CNT_W      (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .detector_out(detector_out),
    .enable      (enable),
    .count_clr   (count_clr),
    .run_active  (run_active),
    .done_pulse  (done_pulse),
    .abort_pulse (abort_pulse),
    .run_count   (run_count),
    .state_dbg   (state_dbg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Scoreboard: run_count value expected at each done pulse, in order.
  logic [CNT_W-1:0] exp_q[$];

  // Reference model, expressed in absolute edge numbers rather than a down-counter.
  int edge_n = 0;
  int m_mode = 0;          // 0 idle, 1 run, 2 cool
  int m_start = 0;
  int m_cool_until = 0;
  int m_count = 0;
  bit m_prev_d = 1'b1;
  bit m_done = 1'b0;
  bit m_abort = 1'b0;

  typedef struct {
    bit det;
    bit en;
    bit clr;
    int reps;
    bit act;
    bit done;
    bit abort;
    int st;
    int cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit d, bit e, bit c, int reps, bit a, bit dn, bit ab, int st, int cnt);
    vec_t v;
    v.det = d; v.en = e; v.clr = c; v.reps = reps;
    v.act = a; v.done = dn; v.abort = ab; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_count  = 0;
    m_prev_d = 1'b1;
    m_done   = 1'b0;
    m_abort  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit d, input bit e, input bit c);
    m_done  = 1'b0;
    m_abort = 1'b0;
    case (m_mode)
      0: if (e && d && !m_prev_d) begin
        m_mode  = 1;
        m_start = edge_n;
      end
      1: if (!d || !e) begin
        m_abort      = 1'b1;
        m_mode       = 2;
        m_cool_until = edge_n + COOL;
      end else if (edge_n - m_start == RUN) begin
        m_done       = 1'b1;
        m_mode       = 2;
        m_cool_until = edge_n + COOL;
        if (m_count < CNT_MAX) m_count++;
      end
      default: if (edge_n == m_cool_until) m_mode = 0;
    endcase
    if (c) m_count = 0;
    if (m_done) exp_q.push_back(CNT_W'(m_count));
    m_prev_d = d;
    edge_n++;
  endtask

  task automatic step(input bit d, input bit e, input bit c);
    detector_out = d;
    enable       = e;
    count_clr    = c;
    @(posedge clock);
    model_edge(d, e, c);
    #1;
    chk("run_active", int'(run_active), int'(m_mode == 1));
    chk("done_pulse", int'(done_pulse), int'(m_done));
    chk("abort_pulse", int'(abort_pulse), int'(m_abort));
    chk("state_dbg", int'(state_dbg), m_mode);
    chk("run_count", int'(run_count), m_count);
    if (done_pulse) begin
      if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
      else chk("sb_done_count", int'(run_count), int'(exp_q.pop_front()));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_active"}, int'(run_active), 0);
    chk({tag, "_done"}, int'(done_pulse), 0);
    chk({tag, "_abort"}, int'(abort_pulse), 0);
    chk({tag, "_count"}, int'(run_count), 0);
    chk({tag, "_state"}, int'(state_dbg), 0);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases on a negedge.
  task automatic reset_dut();
    reset        = 1'b1;
    detector_out = 1'b1;
    enable       = 1'b1;
    count_clr    = 1'b0;
    #1;
    check_all_zero("reset");
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_rise();
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    bit d, e, c;
    reset        = 1'b1;
    detector_out = 1'b1;
    enable       = 1'b1;
    count_clr    = 1'b0;

    // det en clr reps | active done abort state count
    vecs.push_back(mk(1, 1, 0,  3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0,  1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 15, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0,  1, 0, 1, 0, 2, 1));
    vecs.push_back(mk(1, 1, 0,  7, 0, 0, 0, 2, 1));
    vecs.push_back(mk(1, 1, 0,  3, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0,  2, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0,  1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0,  4, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0,  1, 0, 0, 1, 2, 1));
    vecs.push_back(mk(0, 1, 0,  7, 0, 0, 0, 2, 1));
    vecs.push_back(mk(0, 1, 0,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0,  1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 1, 2, 1));
    vecs.push_back(mk(1, 1, 0,  7, 0, 0, 0, 2, 1));
    vecs.push_back(mk(1, 1, 0,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1,  1, 0, 0, 0, 0, 0));

    reset_dut();

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        step(vecs[i].det, vecs[i].en, vecs[i].clr);
        chk($sformatf("tbl%0d_active", i), int'(run_active), int'(vecs[i].act));
        chk($sformatf("tbl%0d_done", i), int'(done_pulse), int'(vecs[i].done));
        chk($sformatf("tbl%0d_abort", i), int'(abort_pulse), int'(vecs[i].abort));
        chk($sformatf("tbl%0d_state", i), int'(state_dbg), vecs[i].st);
        chk($sformatf("tbl%0d_count", i), int'(run_count), vecs[i].cnt);
      end
    end

    // Rise during COOL is ignored; COOL lasts exactly COOL edges.
    reset_dut();
    run_rise();
    for (int i = 0; i < RUN; i++) step(1'b1, 1'b1, 1'b0);
    chk("cool_entry_done", int'(done_pulse), 1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("cool_rise_ignored", int'(state_dbg), 2);
    for (int i = 0; i < COOL - 3; i++) step(1'b1, 1'b1, 1'b0);
    chk("cool_last_edge", int'(state_dbg), 2);
    step(1'b1, 1'b1, 1'b0);
    chk("cool_to_idle", int'(state_dbg), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("no_retrigger", int'(state_dbg), 0);

    // Detector and enable drop on the final RUN edge: abort only, count unchanged.
    run_rise();
    for (int i = 0; i < RUN - 1; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("late_abort_pulse", int'(abort_pulse), 1);
    chk("late_abort_nodone", int'(done_pulse), 0);
    chk("late_abort_count", int'(run_count), 1);
    for (int i = 0; i < COOL; i++) step(1'b1, 1'b1, 1'b0);

    // Saturation at all-ones.
    reset_dut();
    for (int n = 0; n < CNT_MAX; n++) begin
      run_rise();
      for (int i = 0; i < RUN; i++) step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < COOL; i++) step(1'b1, 1'b1, 1'b0);
    end
    chk("preload_255", int'(run_count), CNT_MAX);
    run_rise();
    for (int i = 0; i < RUN; i++) step(1'b1, 1'b1, 1'b0);
    chk("sat_done", int'(done_pulse), 1);
    chk("sat_count", int'(run_count), CNT_MAX);
    for (int i = 0; i < COOL; i++) step(1'b1, 1'b1, 1'b0);

    // count_clr on the completing edge wins.
    run_rise();
    for (int i = 0; i < RUN - 1; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_done_pulse", int'(done_pulse), 1);
    chk("clr_wins", int'(run_count), 0);
    for (int i = 0; i < COOL; i++) step(1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-RUN.
    run_rise();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    chk("pre_reset_active", int'(run_active), 1);
    #2;
    reset_dut();

    // Random stimulus against the model.
    d = 1'b1;
    e = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) d = ~d;
      e = ($urandom_range(0, 31) != 0);
      c = ($urandom_range(0, 99) == 0);
      step(d, e, c);
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
